// File: rtl/bus_arbiter_8.sv
// Eight-way round-robin arbiter for a shared byte bus with a bounded hold time.
// A release always passes through one idle cycle before the next owner is granted.
module bus_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  request,
  input  logic [63:0] data_input,
  output logic [7:0]  grant,
  output logic [2:0]  selector,
  output logic [7:0]  bus_data,
  output logic        bus_data_valid
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            r_state;
  logic [7:0]        r_grant;
  logic [2:0]        r_sel;
  logic [2:0]        r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        r_bus;
  logic              r_valid;

  logic              w_any;
  logic [2:0]        w_pick;
  logic              w_owner_req;
  logic [7:0]        w_owner_byte;
  logic              w_release;

  // First requester at or after the pointer; scanning downward lets the nearest one win.
  always_comb begin
    w_pick = r_ptr;
    w_any  = |request;
    for (int i = 7; i >= 0; i--) begin
      if (request[3'(r_ptr + 3'(i))]) begin
        w_pick = 3'(r_ptr + 3'(i));
      end
    end
  end

  assign w_owner_req  = request[r_sel];
  assign w_owner_byte = data_input[{r_sel, 3'b000} +: 8];
  assign w_release    = !w_owner_req || (r_hold == HOLD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_bus   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == S_GRANT);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_sel   <= w_pick;
            r_grant <= 8'd1 << w_pick;
            r_hold  <= '0;
          end
        end
        S_GRANT: begin
          r_bus <= w_owner_byte;
          // Voluntary drop and hold expiry share one release path and one pointer step.
          if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= 3'(r_sel + 3'd1);
          end else begin
            r_hold  <= HOLD_W'(r_hold + 1'b1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant          = r_grant;
  assign selector       = r_sel;
  assign bus_data       = r_bus;
  assign bus_data_valid = r_valid;

endmodule

// File: doc/bus_arbiter_8.md
BUS_ARBITER_8 -- requirements
Module: bus_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, the maximum number of consecutive cycles one requester may hold the grant (legal range 1..256).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port request, input, 8 bits: bit i high means requester i wants the shared 8-bit bus.
REQ-005 SHALL have port data_input, input, 64 bits: requester i drives byte data_input[8*i+7 : 8*i].
REQ-006 SHALL have port grant, output, 8 bits: registered one-hot grant, all zero when no owner.
REQ-007 SHALL have port selector, output, 3 bits: registered index of the current or most recent owner.
REQ-008 SHALL have port bus_data, output, 8 bits: registered copy of the owner's byte.
REQ-009 SHALL have port bus_data_valid, output, 1 bit: high when bus_data holds a byte captured during a grant cycle.

Function
REQ-010 SHALL implement two states, IDLE (grant = 0) and GRANT (grant = one-hot of selector).
REQ-011 SHALL keep a 3-bit priority pointer; search order is pointer, pointer+1, ..., pointer+7, mod 8.
REQ-012 In IDLE with request != 0 at a rising edge, SHALL move to GRANT, set selector to the first requesting index in search order, set grant to its one-hot, and clear the hold counter.
REQ-013 In IDLE with request == 0, SHALL stay in IDLE; selector and pointer SHALL hold their values.
REQ-014 Request-to-grant latency SHALL be exactly one clock edge from IDLE.
REQ-015 In GRANT, the hold counter SHALL increment once per edge. It SHALL be wide enough for MAX_HOLD-1 with no wrap.
REQ-016 In GRANT, if request[selector] is low at an edge, SHALL return to IDLE (grant = 0) and set pointer = selector+1 mod 8.
REQ-017 In GRANT, if the hold counter equals MAX_HOLD-1 at an edge, SHALL return to IDLE and set pointer = selector+1 mod 8, even when request[selector] is still high (forced release).
REQ-018 REQ-016 and REQ-017 true at the same edge SHALL give one release and one pointer update.
REQ-019 Every ownership change SHALL pass through at least one IDLE cycle with grant = 0 (bus turnaround); grant SHALL never have more than one bit set.
REQ-020 A requester dropping and reasserting request during the IDLE gap SHALL get no priority over requesters later in search order.
REQ-021 At each edge, bus_data_valid SHALL be set to (state == GRANT). When state == GRANT, bus_data SHALL load data_input[8*selector+7 : 8*selector]; otherwise bus_data SHALL hold its value. Data latency is one cycle after each grant cycle.
REQ-022 Changes on request bits other than the owner's during GRANT SHALL not affect the current grant.
REQ-023 With MAX_HOLD = 1, every grant SHALL last exactly one cycle.

Reset
REQ-024 Reset assertion SHALL immediately set state = IDLE, grant = 0, selector = 0, pointer = 0, hold counter = 0, bus_data = 0x00, bus_data_valid = 0, including in the middle of a grant.
REQ-025 After reset deassertion, the first arbitration SHALL use pointer = 0.

Verification
REQ-026 Single requester: reset, then request = 0x04 held 3 cycles then dropped, data_input byte 2 = 0xA5 -> grant = 0x04 for 3 cycles, selector = 2, bus_data = 0xA5 with bus_data_valid high for 3 cycles one cycle later, then IDLE.
REQ-027 Round robin: request = 0xFF, each owner drops request one cycle after its grant and reasserts it in the IDLE gap -> grant order 0x01, 0x02, 0x04, ..., 0x80, 0x01, with one zero-grant cycle between owners.
REQ-028 Forced release: MAX_HOLD = 4, request = 0x09 held constant -> grant 0x01 for 4 cycles, 1 idle cycle, 0x08 for 4 cycles, 1 idle cycle, 0x01 again.
REQ-029 Wrap-around: pointer = 7 after owner 6 releases, request = 0x81 -> grant 0x80 first, then 0x01.
REQ-030 Reset mid-grant: assert reset in the 2nd cycle of grant 0x10 -> grant, bus_data_valid and selector read 0 in that same cycle; after release, request = 0x10 is granted again with pointer = 0 search.
REQ-031 One-hot check: random request for 10k cycles -> grant is always 0 or one-hot, no grant exceeds MAX_HOLD cycles, every persistent requester is granted within 8 × (MAX_HOLD+1) cycles.
